// File: rtl/tile_pkg.sv
// tile_pkg: mode encodings, pipeline latency and the fixed colour palette
// shared by the tile plane and the sprite mixer.
package tile_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_G1   = 2'd1,
        MODE_G2   = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam int LAT = 4;

    // TMS9918 colours in 12-bit RGB; entry 0 doubles as "transparent".
    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h000, 12'h2C4, 12'h5D7,
        12'h54F, 12'h77F, 12'hD54, 12'h4EF,
        12'hF55, 12'hF77, 12'hDC3, 12'hEC8,
        12'h2B3, 12'hC5B, 12'hCCC, 12'hFFF
    };

    function automatic int scale_log2(input int s);
        int n;
        n = 0;
        while ((1 << n) < s) n = n + 1;
        return n;
    endfunction

endpackage

// File: rtl/tile_palette.sv
// tile_palette: registered 4-bit index to 12-bit RGB lookup.
// Shared with the sprite mixer so both planes use the same colours.
module tile_palette
    import tile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  index,
    output logic [11:0] rgb
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rgb <= '0;
        else       rgb <= PALETTE[index];
    end

endmodule

// File: rtl/tile_plane.sv
// tile_plane: tile-mode background renderer. Position in, four stages
// through name/pattern/colour fetches, registered RGB out.
module tile_plane
    import tile_pkg::*;
#(
    parameter int SCALE = 2,
    parameter int COLS  = 32,
    parameter int ROWS  = 24,
    parameter int VA_W  = 14
) (
    input  logic            pxclk,
    input  logic            reset,
    input  logic            hsync_in,
    input  logic            vsync_in,
    input  logic            active_in,
    input  logic            border_in,
    input  logic [9:0]      col_in,
    input  logic [9:0]      row_in,
    input  logic [1:0]      cfg_mode,
    input  logic [3:0]      cfg_name_base,
    input  logic [2:0]      cfg_pattern_base,
    input  logic [7:0]      cfg_colour_base,
    input  logic [3:0]      cfg_backdrop,
    output logic            hsync_out,
    output logic            vsync_out,
    output logic            active_out,
    output logic            border_out,
    output logic [VA_W-1:0] name_raddr,
    input  logic [7:0]      name_rdata,
    output logic [VA_W-1:0] pattern_raddr,
    input  logic [7:0]      pattern_rdata,
    output logic [VA_W-1:0] colour_raddr,
    input  logic [7:0]      colour_rdata,
    output logic [11:0]     rgb
);

    localparam int SH = scale_log2(SCALE);

    mode_e      sh_mode;
    logic [3:0] sh_name;
    logic [2:0] sh_pat;
    logic [7:0] sh_col;
    logic [3:0] sh_bd;
    logic       vs_prev;

    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) begin
            vs_prev <= 1'b0;
            sh_mode <= MODE_OFF;
            sh_name <= '0;
            sh_pat  <= '0;
            sh_col  <= '0;
            sh_bd   <= '0;
        end else begin
            vs_prev <= vsync_in;
            if (vsync_in && !vs_prev) begin
                sh_mode <= mode_e'(cfg_mode);
                sh_name <= cfg_name_base;
                sh_pat  <= cfg_pattern_base;
                sh_col  <= cfg_colour_base;
                sh_bd   <= cfg_backdrop;
            end
        end
    end

    logic [7:0] px;
    logic [7:0] py;
    logic       in_area;

    assign px = 8'(col_in >> SH);
    assign py = 8'(row_in >> SH);
    assign in_area = (int'(col_in) < COLS * 8 * SCALE)
                  && (int'(row_in) < ROWS * 8 * SCALE);
    assign name_raddr = VA_W'({sh_name, py[7:3], px[7:3]});

    logic [2:0]     c1;
    logic [2:0]     c2;
    logic [2:0]     r1;
    logic [1:0]     third1;
    logic           area1;
    logic           area2;
    logic [LAT-1:0] hs_d;
    logic [LAT-1:0] vs_d;
    logic [LAT-1:0] act_d;
    logic [LAT-1:0] bd_d;
    logic [3:0]     idx3;
    logic [3:0]     pix_idx;

    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) begin
            c1     <= '0;
            c2     <= '0;
            r1     <= '0;
            third1 <= '0;
            area1  <= 1'b0;
            area2  <= 1'b0;
            hs_d   <= '0;
            vs_d   <= '0;
            act_d  <= '0;
            bd_d   <= '0;
            idx3   <= '0;
        end else begin
            c1     <= px[2:0];
            r1     <= py[2:0];
            third1 <= py[7:6];
            area1  <= in_area;
            c2     <= c1;
            area2  <= area1;
            hs_d   <= {hs_d[LAT-2:0], hsync_in};
            vs_d   <= {vs_d[LAT-2:0], vsync_in};
            act_d  <= {act_d[LAT-2:0], active_in};
            bd_d   <= {bd_d[LAT-2:0], border_in};
            idx3   <= pix_idx;
        end
    end

    always_comb begin
        pattern_raddr = '0;
        colour_raddr  = '0;
        unique case (sh_mode)
            MODE_G1: begin
                pattern_raddr = VA_W'({sh_pat, name_rdata, r1});
                colour_raddr  = VA_W'({sh_col, 1'b0, name_rdata[7:3]});
            end
            MODE_G2: begin
                pattern_raddr = VA_W'({sh_pat[2], third1, name_rdata, r1});
                colour_raddr  = VA_W'({sh_col[7], third1, name_rdata, r1});
            end
            default: ;
        endcase
    end

    logic       pat_bit;
    logic       mode_on;
    logic [3:0] fg_idx;

    assign mode_on = (sh_mode == MODE_G1) || (sh_mode == MODE_G2);

    // Timing taps at index 1 belong to the pixel whose data is now in S2.
    always_comb begin
        pat_bit = pattern_rdata[3'd7 - c2];
        fg_idx  = pat_bit ? colour_rdata[7:4] : colour_rdata[3:0];
        if (fg_idx == 4'd0) fg_idx = sh_bd;
        pix_idx = fg_idx;
        if (bd_d[1])                 pix_idx = sh_bd;
        else if (!act_d[1])          pix_idx = 4'd0;
        else if (!mode_on || !area2) pix_idx = sh_bd;
        else                         pix_idx = fg_idx;
    end

    tile_palette u_palette (
        .clk   (pxclk),
        .reset (reset),
        .index (idx3),
        .rgb   (rgb)
    );

    assign hsync_out  = hs_d[LAT-1];
    assign vsync_out  = vs_d[LAT-1];
    assign active_out = act_d[LAT-1];
    assign border_out = bd_d[LAT-1];

endmodule
